// File: rtl/exc_redirect_ctrl.sv
// rtl/exc_redirect_ctrl.sv - flush sequencing and fetch redirect after CP0 exception/ERET
module exc_redirect_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_1,
    input  logic        exc_2,
    input  logic        cln_1,
    input  logic        cln_2,
    input  logic [31:0] epc,
    input  logic        if_ready,
    output logic        kill_lane2_mem,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  flush_cnt;
    logic        lane1_act;
    logic        lane2_act;
    logic        any_ev;
    logic        take_ev;
    logic        drop_ev;
    logic [31:0] target_pc;

    // A bare exc_x without cln_x is a soft interrupt: it still counts as a lane event.
    assign lane1_act = cln_1 | exc_1;
    assign lane2_act = cln_2 | exc_2;
    assign any_ev    = lane1_act | lane2_act;
    assign take_ev   = (state == S_IDLE) & any_ev;
    assign drop_ev   = (state != S_IDLE) & any_ev;

    always_comb begin
        target_pc = epc;
        if (lane1_act) begin
            if (exc_1) target_pc = EXC_VECTOR;
        end else if (exc_2) begin
            target_pc = EXC_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_ev) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_cnt == 4'd0) state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (if_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flush_cnt   <= 4'd0;
            redirect_pc <= 32'd0;
            drop_cnt    <= 8'd0;
        end else begin
            if (take_ev) begin
                flush_cnt   <= FLUSH_LOAD;
                redirect_pc <= target_pc;
            end else if (state == S_FLUSH && flush_cnt != 4'd0) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
            // Events while busy are not queued, only counted (saturating).
            if (drop_ev && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        flush_if_id    = (state == S_FLUSH);
        flush_id_ex    = (state == S_FLUSH);
        flush_ex_mem   = (state == S_FLUSH);
        redirect_valid = (state == S_REDIRECT);
        busy           = (state != S_IDLE);
        kill_lane2_mem = (state == S_IDLE) & cln_1 & reset;
    end

endmodule
